// File: rtl/snake_body_tracker.sv
// Snake segment register file with the move/grow sequencer: wall check, serial
// self-collision scan, then a one-cycle body shift with optional growth.
module snake_body_tracker #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned INIT_X   = 10,
    parameter int unsigned INIT_Y   = 10,
    parameter int unsigned GRID_MAX = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [1:0] dir,
    input  logic       grow,
    input  logic [4:0] next_x,
    input  logic [4:0] next_y,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] len,
    input  logic [3:0] rd_idx,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    output logic       rd_valid,
    output logic       busy,
    output logic       step_done,
    output logic       game_over
);

    localparam int unsigned CW = 5;
    localparam int unsigned IW = 4;
    localparam logic [CW-1:0] GRID    = CW'(GRID_MAX);
    localparam logic [CW-1:0] LEN_CAP = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        RUN,
        SCAN,
        UPDATE,
        DEAD
    } state_t;

    state_t        state;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];
    logic [IW-1:0] idx;
    logic [IW-1:0] last_idx;
    logic [CW-1:0] lat_x;
    logic [CW-1:0] lat_y;
    logic          lat_g;
    logic          wall_c;
    logic          grow_eff_c;

    // A move that would leave the grid is caught before the adder wrap matters.
    always_comb begin
        wall_c = 1'b0;
        case (dir)
            2'b00:   wall_c = (seg_y[0] == '0);
            2'b01:   wall_c = (seg_x[0] == GRID);
            2'b10:   wall_c = (seg_y[0] == GRID);
            default: wall_c = (seg_x[0] == '0);
        endcase
    end

    assign grow_eff_c = grow && (len < LEN_CAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x[IW'(i)] <= CW'(INIT_X - i);
                    seg_y[IW'(i)] <= CW'(INIT_Y);
                end else begin
                    seg_x[IW'(i)] <= '0;
                    seg_y[IW'(i)] <= '0;
                end
            end
            len       <= CW'(INIT_LEN);
            state     <= RUN;
            idx       <= '0;
            last_idx  <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_g     <= 1'b0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                RUN: begin
                    if (step) begin
                        if (wall_c) begin
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end else begin
                            lat_x    <= next_x;
                            lat_y    <= next_y;
                            lat_g    <= grow_eff_c;
                            // The tail vacates on a plain move, so it is skipped.
                            last_idx <= grow_eff_c ? IW'(len - 5'd1) : IW'(len - 5'd2);
                            idx      <= '0;
                            busy     <= 1'b1;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (seg_x[idx] == lat_x && seg_y[idx] == lat_y) begin
                        state     <= DEAD;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                    end else if (idx == last_idx) begin
                        state <= UPDATE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                UPDATE: begin
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        seg_x[IW'(i)] <= seg_x[IW'(i - 1)];
                        seg_y[IW'(i)] <= seg_y[IW'(i - 1)];
                    end
                    seg_x[0]  <= lat_x;
                    seg_y[0]  <= lat_y;
                    len       <= len + CW'(lat_g);
                    busy      <= 1'b0;
                    step_done <= 1'b1;
                    state     <= RUN;
                end
                default: begin
                    state <= DEAD;
                end
            endcase
        end
    end

    assign head_x   = seg_x[0];
    assign head_y   = seg_y[0];
    assign rd_x     = seg_x[rd_idx];
    assign rd_y     = seg_y[rd_idx];
    assign rd_valid = ({1'b0, rd_idx} < len);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboarded random/directed bench for snake_body_tracker against a queue-based snake model.
module tb_snake_body_tracker;

    localparam int unsigned MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b01;
    logic       grow = 1'b0;
    logic [4:0] next_x = '0;
    logic [4:0] next_y = '0;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [4:0] len;
    logic [3:0] rd_idx = '0;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_valid;
    logic       busy;
    logic       step_done;
    logic       game_over;

    snake_body_tracker dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
        .next_x(next_x), .next_y(next_y), .head_x(head_x), .head_y(head_y),
        .len(len), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .busy(busy), .step_done(step_done), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit dead;
        int at;
        int nbusy;
        int hx;
        int hy;
        int ln;
    } exp_t;

    exp_t sbq[$];

    // Reference snake: front of the queue is the head.
    int  mx[$];
    int  my[$];
    bit  m_dead;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        mx = '{10, 9, 8};
        my = '{10, 10, 10};
        m_dead = 1'b0;
    endfunction

    // Monitor: pops an expectation whenever the DUT reports a finished step or death.
    initial begin
        bit go_q;
        int brun;
        exp_t e;
        go_q = 1'b0;
        brun = 0;
        forever begin
            @(negedge clk);
            if (!rst && (step_done || (game_over && !go_q))) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: step_done=%0b game_over=%0b with nothing expected (cycle %0d)",
                             step_done, game_over, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("event_kind", int'(game_over), int'(e.dead));
                    check("event_cycle", cyc, e.at);
                    check("busy_cycles", brun, e.nbusy);
                    check("head_x", int'(head_x), e.hx);
                    check("head_y", int'(head_y), e.hy);
                    check("len", int'(len), e.ln);
                end
            end
            if (busy) brun++;
            else brun = 0;
            go_q = game_over;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        step = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        model_reset();
    endtask

    // Issues one step with the adder sum computed from the model head; dbl adds an ignored pulse.
    task automatic do_step(input logic [1:0] d, input bit g, input bit dbl);
        logic [4:0] nx;
        logic [4:0] ny;
        bit   wall;
        bit   gg;
        int   n;
        int   hit;
        exp_t e;
        @(negedge clk);
        nx = 5'(mx[0]);
        ny = 5'(my[0]);
        case (d)
            2'b00:   ny = ny - 5'd1;
            2'b01:   nx = nx + 5'd1;
            2'b10:   ny = ny + 5'd1;
            default: nx = nx - 5'd1;
        endcase
        dir = d; grow = g; next_x = nx; next_y = ny; step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        if (!m_dead) begin
            wall = (d == 2'b01 && mx[0] == 31) || (d == 2'b11 && mx[0] == 0) ||
                   (d == 2'b00 && my[0] == 0)  || (d == 2'b10 && my[0] == 31);
            if (wall) begin
                m_dead = 1'b1;
                e = '{1'b1, cyc, 0, mx[0], my[0], mx.size()};
            end else begin
                gg  = g && (mx.size() < MAX_LEN);
                n   = gg ? mx.size() : mx.size() - 1;
                hit = -1;
                for (int k = 0; k < n; k++)
                    if (hit < 0 && mx[k] == int'(nx) && my[k] == int'(ny)) hit = k;
                if (hit >= 0) begin
                    m_dead = 1'b1;
                    e = '{1'b1, cyc + hit + 1, hit + 1, mx[0], my[0], mx.size()};
                end else begin
                    mx.push_front(int'(nx));
                    my.push_front(int'(ny));
                    if (!gg) begin
                        void'(mx.pop_back());
                        void'(my.pop_back());
                    end
                    e = '{1'b0, cyc + n + 1, n + 1, mx[0], my[0], mx.size()};
                end
            end
            sbq.push_back(e);
        end
        if (dbl) begin
            @(negedge clk);
            dir = ~d; grow = ~g; next_x = ~nx; next_y = ny; step = 1'b1;
            @(posedge clk);
            #1 step = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expected events still pending (cycle %0d)", sbq.size(), cyc);
            sbq.delete();
        end
    endtask

    task automatic check_body();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("rd_valid[%0d]", i), int'(rd_valid), int'(i < mx.size()));
            if (i < mx.size()) begin
                check($sformatf("seg_x[%0d]", i), int'(rd_x), mx[i]);
                check($sformatf("seg_y[%0d]", i), int'(rd_y), my[i]);
            end
        end
        check("len_idle", int'(len), mx.size());
        check("game_over_flag", int'(game_over), int'(m_dead));
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_head_x", int'(head_x), 10);
        check("rst_head_y", int'(head_y), 10);
        check("rst_len", int'(len), 3);
        check("rst_step_done", int'(step_done), 0);
        check_body();

        // Plain move right, then a grow move.
        do_step(2'b01, 1'b0, 1'b0);
        wait_idle();
        check_body();
        do_step(2'b01, 1'b1, 1'b1);
        wait_idle();
        check_body();

        // Run into the right wall; further steps are ignored.
        while (mx[0] < 31) begin
            do_step(2'b01, 1'b0, 1'b0);
            wait_idle();
        end
        do_step(2'b01, 1'b0, 1'b0);
        wait_idle();
        do_step(2'b10, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        check("dead_head_x", int'(head_x), 31);
        check_body();

        // Reverse into the neck.
        apply_reset();
        do_step(2'b11, 1'b0, 1'b0);
        wait_idle();
        check_body();

        // Grow to capacity, then one more grow at the cap.
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            do_step(2'b01, 1'b1, 1'b0);
            wait_idle();
        end
        check_body();

        // Reset in the middle of a scan.
        apply_reset();
        do_step(2'b10, 1'b0, 1'b0);
        apply_reset();
        repeat (8) @(posedge clk);
        check("midscan_len", int'(len), 3);
        check_body();

        // Random play, restarting after each death.
        apply_reset();
        for (int it = 0; it < 250; it++) begin
            do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
            wait_idle();
            if (it % 10 == 0 || m_dead) check_body();
            if (m_dead) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
